functional_unit: RTL and testbench
==================================

// Module: functional_unit
// PURPOSE
// - Integer execute unit of the out-of-order core; three instances sit between the reservation station and the
//   wakeup/broadcast network.
// - Takes one issued micro-op (operands already read), computes an ALU result or a load/store address,
//   and returns it a fixed LATENCY later.
// - ALU results are broadcast as a tagged wakeup (RS, rename, ROB); L/S addresses go to the LSQ.
// PARAMETERS
// - LATENCY  1  cycles from accepted issue to result pulse; legal 1..4; unit is non-pipelined
// - DATA_W  32  operand/result width
// - TAG_W    6  physical register tag width
// - ROB_W    6  ROB index width
// PORTS
// - clk                   in   1       single clock, rising edge
// - reset                 in   1       asynchronous, active-high
// - write_enable          in   1       issue valid this cycle
// - ALUControl            in   4       operation select (encoding below)
// - ALUSrc                in   1       1: operand B = imm; 0: operand B = rs2_value
// - is_for_lsq            in   1       1: micro-op is load/store address generation
// - imm                   in   32      sign-extended immediate
// - rs1_value             in   32      operand A
// - rs2_value             in   32      register operand B
// - tag_to_output         in   TAG_W   destination physical tag
// - rob_index             in   ROB_W   ROB entry of the micro-op
// - is_available          out  1       unit can accept an issue this cycle
// - wakeup_active         out  1       one-cycle ALU result broadcast
// - wakeup_rob_index      out  ROB_W   ROB entry of the broadcast
// - wakeup_tag            out  TAG_W   destination tag of the broadcast
// - wakeup_value          out  32      ALU result
// - lsq_wakeup_active     out  1       one-cycle address-ready pulse to the LSQ
// - lsq_wakeup_rob_index  out  ROB_W   ROB entry of the L/S op
// - lsq_wakeup_value      out  32      effective address
// BEHAVIOUR
// - ALUControl encoding (B = selected operand B):
//   - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//   - 5 SLL, 6 SRL, 7 SRA; shift amount B[4:0]
//   - 8 SLT (signed), 9 SLTU
//   - 10 LUI: result = B
//   - 11..15 reserved: result = 0
// - All arithmetic is 32-bit and wraps modulo 2^32; no overflow flags.
// - is_for_lsq=1: address = rs1_value + imm, regardless of ALUControl and ALUSrc.
// - Accept: issue is taken on a rising edge when write_enable && is_available.
//   - write_enable while !is_available is ignored; the input is dropped and no state changes.
//   - All operands, tag and rob_index are latched at accept.
// - Result timing: an accept at edge N produces a result valid for exactly one cycle after edge N+LATENCY-1.
//   - For LATENCY=1, outputs are registered and the pulse follows the accept edge directly.
// - is_available:
//   - LATENCY=1: is_available stays 1 permanently, so back-to-back issues every cycle give back-to-back pulses.
//   - LATENCY>1: is_available drops on the edge after accept and returns to 1 in the same cycle the result
//     pulses, so a new issue may be accepted that cycle.
// - Result steering:
//   - ALU op: wakeup_active=1 and lsq_wakeup_active=0.
//   - L/S op: lsq_wakeup_active=1 and wakeup_active=0.
//   - The two pulses are never high together.
// - Inactive outputs: when a pulse is low, its rob_index/tag/value outputs are driven 0.
// - Tag 0 (hardwired zero register): the wakeup still pulses, but wakeup_value is forced to 0.
// - Reset (asynchronous, including mid-operation): any in-flight op is discarded and all pulse and data
//   outputs go to 0; is_available=1.
//   - The first accept is possible on the first rising edge after reset deasserts.
// STRUCTURE
// - Shared package cpu_pkg holds the ALU op localparams (ALU_ADD..ALU_LUI) and the TAG_W/ROB_W/DATA_W constants;
//   decode and the reservation station use the same package.
// - Sub-module alu_core: purely combinational, (op, a, b) -> result.
// - functional_unit wraps alu_core with the operand mux, the latency counter/valid shift and output steering.
// TESTING
// - ADD reg: rs1=5, rs2=7, ALUSrc=0, tag=12, rob=3, we=1 -> next cycle wakeup_active=1, tag=12, rob=3,
//   value=12; lsq pulse stays 0.
// - SUB and SRA: SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000 by imm=4 (ALUSrc=1) -> 0xF8000000;
//   SLTU 1 vs 0xFFFFFFFF -> 1; SLT -> 0.
// - L/S address: is_for_lsq=1, rs1=0x100, imm=-4, rob=9 -> lsq_wakeup_active=1, value=0xFC, rob=9;
//   wakeup_active stays 0.
// - Back-to-back (LATENCY=1): issue on 3 consecutive cycles -> 3 consecutive correct pulses;
//   is_available never drops.
// - LATENCY=3: issue, then we=1 on the next 2 cycles -> both ignored, is_available=0 for 2 cycles,
//   single pulse 3 cycles after accept.
// - Reset mid-flight (LATENCY=3): assert reset 1 cycle after accept -> no pulse ever appears;
//   all outputs 0; is_available=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core widths and ALU operation encodings
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int ROB_W  = 6;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer ALU, (op, a, b) -> result
module alu_core
  import cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, a < b};
      ALU_LUI:  result = b;
      // reserved encodings deliberately produce zero
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/functional_unit.sv
// rtl/functional_unit.sv - non-pipelined integer execute unit with fixed-latency tagged wakeup
module functional_unit #(
  parameter int LATENCY = 1,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int TAG_W   = cpu_pkg::TAG_W,
  parameter int ROB_W   = cpu_pkg::ROB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [3:0]        ALUControl,
  input  logic              ALUSrc,
  input  logic              is_for_lsq,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rs1_value,
  input  logic [DATA_W-1:0] rs2_value,
  input  logic [TAG_W-1:0]  tag_to_output,
  input  logic [ROB_W-1:0]  rob_index,
  output logic              is_available,
  output logic              wakeup_active,
  output logic [ROB_W-1:0]  wakeup_rob_index,
  output logic [TAG_W-1:0]  wakeup_tag,
  output logic [DATA_W-1:0] wakeup_value,
  output logic              lsq_wakeup_active,
  output logic [ROB_W-1:0]  lsq_wakeup_rob_index,
  output logic [DATA_W-1:0] lsq_wakeup_value
);

  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] issue_value;
  logic              accept;

  logic              busy_d, busy_q;
  logic [1:0]        cnt_d, cnt_q;
  logic [DATA_W-1:0] hold_value_d, hold_value_q;
  logic [TAG_W-1:0]  hold_tag_d, hold_tag_q;
  logic [ROB_W-1:0]  hold_rob_d, hold_rob_q;
  logic              hold_lsq_d, hold_lsq_q;

  logic              fire;
  logic [DATA_W-1:0] fire_value;
  logic [TAG_W-1:0]  fire_tag;
  logic [ROB_W-1:0]  fire_rob;
  logic              fire_lsq;

  logic              wake_act_d, wake_act_q;
  logic [ROB_W-1:0]  wake_rob_d, wake_rob_q;
  logic [TAG_W-1:0]  wake_tag_d, wake_tag_q;
  logic [DATA_W-1:0] wake_val_d, wake_val_q;
  logic              lsq_act_d, lsq_act_q;
  logic [ROB_W-1:0]  lsq_rob_d, lsq_rob_q;
  logic [DATA_W-1:0] lsq_val_d, lsq_val_q;

  assign operand_b = ALUSrc ? imm : rs2_value;

  alu_core u_alu (
    .op     (ALUControl),
    .a      (rs1_value),
    .b      (operand_b),
    .result (alu_result)
  );

  // Result is computed at accept and held; operands never change while in flight.
  always_comb begin
    issue_value = '0;
    if (is_for_lsq)
      issue_value = rs1_value + imm;
    else if (tag_to_output != '0)
      issue_value = alu_result;
  end

  assign is_available = !busy_q;
  assign accept       = write_enable && is_available;

  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    hold_value_d = hold_value_q;
    hold_tag_d   = hold_tag_q;
    hold_rob_d   = hold_rob_q;
    hold_lsq_d   = hold_lsq_q;
    fire         = 1'b0;
    fire_value   = hold_value_q;
    fire_tag     = hold_tag_q;
    fire_rob     = hold_rob_q;
    fire_lsq     = hold_lsq_q;
    if (LATENCY == 1) begin
      if (accept) begin
        fire       = 1'b1;
        fire_value = issue_value;
        fire_tag   = tag_to_output;
        fire_rob   = rob_index;
        fire_lsq   = is_for_lsq;
      end
    end else begin
      if (busy_q) begin
        if (cnt_q == 2'd1) begin
          fire   = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      if (accept) begin
        busy_d       = 1'b1;
        cnt_d        = CNT_INIT;
        hold_value_d = issue_value;
        hold_tag_d   = tag_to_output;
        hold_rob_d   = rob_index;
        hold_lsq_d   = is_for_lsq;
      end
    end
  end

  always_comb begin
    wake_act_d = fire && !fire_lsq;
    wake_rob_d = wake_act_d ? fire_rob : '0;
    wake_tag_d = wake_act_d ? fire_tag : '0;
    wake_val_d = wake_act_d ? fire_value : '0;
    lsq_act_d  = fire && fire_lsq;
    lsq_rob_d  = lsq_act_d ? fire_rob : '0;
    lsq_val_d  = lsq_act_d ? fire_value : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      hold_value_q <= '0;
      hold_tag_q   <= '0;
      hold_rob_q   <= '0;
      hold_lsq_q   <= 1'b0;
      wake_act_q   <= 1'b0;
      wake_rob_q   <= '0;
      wake_tag_q   <= '0;
      wake_val_q   <= '0;
      lsq_act_q    <= 1'b0;
      lsq_rob_q    <= '0;
      lsq_val_q    <= '0;
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      hold_value_q <= hold_value_d;
      hold_tag_q   <= hold_tag_d;
      hold_rob_q   <= hold_rob_d;
      hold_lsq_q   <= hold_lsq_d;
      wake_act_q   <= wake_act_d;
      wake_rob_q   <= wake_rob_d;
      wake_tag_q   <= wake_tag_d;
      wake_val_q   <= wake_val_d;
      lsq_act_q    <= lsq_act_d;
      lsq_rob_q    <= lsq_rob_d;
      lsq_val_q    <= lsq_val_d;
    end
  end

  assign wakeup_active        = wake_act_q;
  assign wakeup_rob_index     = wake_rob_q;
  assign wakeup_tag           = wake_tag_q;
  assign wakeup_value         = wake_val_q;
  assign lsq_wakeup_active    = lsq_act_q;
  assign lsq_wakeup_rob_index = lsq_rob_q;
  assign lsq_wakeup_value     = lsq_val_q;

endmodule

// File: tb/tb_functional_unit.sv
// tb/tb_functional_unit.sv - directed-vector bench for functional_unit at LATENCY 1 and 3
module tb_functional_unit;

  logic        clk = 1'b0;
  logic        rst1, rst3, we1, we3;
  logic [3:0]  alu_ctl;
  logic        alu_src, is_lsq;
  logic [31:0] imm, rs1, rs2;
  logic [5:0]  tag, rob;

  logic        avail1, wa1, lwa1, avail3, wa3, lwa3;
  logic [5:0]  wrob1, wtag1, lrob1, wrob3, wtag3, lrob3;
  logic [31:0] wval1, lval1, wval3, lval3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  functional_unit #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1), .write_enable(we1), .ALUControl(alu_ctl), .ALUSrc(alu_src),
    .is_for_lsq(is_lsq), .imm(imm), .rs1_value(rs1), .rs2_value(rs2), .tag_to_output(tag),
    .rob_index(rob), .is_available(avail1), .wakeup_active(wa1), .wakeup_rob_index(wrob1),
    .wakeup_tag(wtag1), .wakeup_value(wval1), .lsq_wakeup_active(lwa1),
    .lsq_wakeup_rob_index(lrob1), .lsq_wakeup_value(lval1)
  );

  functional_unit #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3), .write_enable(we3), .ALUControl(alu_ctl), .ALUSrc(alu_src),
    .is_for_lsq(is_lsq), .imm(imm), .rs1_value(rs1), .rs2_value(rs2), .tag_to_output(tag),
    .rob_index(rob), .is_available(avail3), .wakeup_active(wa3), .wakeup_rob_index(wrob3),
    .wakeup_tag(wtag3), .wakeup_value(wval3), .lsq_wakeup_active(lwa3),
    .lsq_wakeup_rob_index(lrob3), .lsq_wakeup_value(lval3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] op, input logic src, input logic lsq, input logic [31:0] i,
                        input logic [31:0] a, input logic [31:0] b, input logic [5:0] t,
                        input logic [5:0] r);
    alu_ctl = op; alu_src = src; is_lsq = lsq; imm = i; rs1 = a; rs2 = b; tag = t; rob = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic a, input logic [5:0] t, input logic [5:0] r,
                      input logic [31:0] v);
    check({name, ".act"}, 32'(wa1), 32'(a));
    check({name, ".tag"}, 32'(wtag1), 32'(t));
    check({name, ".rob"}, 32'(wrob1), 32'(r));
    check({name, ".val"}, wval1, v);
    check({name, ".lsq"}, 32'(lwa1), 32'd0);
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; we1 = 1'b0; we3 = 1'b0;
    set_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.avail1", 32'(avail1), 32'd1);
    check("rst.avail3", 32'(avail3), 32'd1);
    chk1("rst", 1'b0, 6'd0, 6'd0, 32'd0);
    check("rst.wa3", 32'(wa3), 32'd0);
    rst1 = 1'b0; rst3 = 1'b0;

    // LATENCY=1 directed ALU vectors, issued back-to-back
    we1 = 1'b1;
    set_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd7, 6'd12, 6'd3);
    tick; chk1("add", 1'b1, 6'd12, 6'd3, 32'd12);
    check("add.lrob", 32'(lrob1), 32'd0);
    set_op(4'd1, 1'b0, 1'b0, 32'd0, 32'd3, 32'd5, 6'd1, 6'd1);
    tick; chk1("sub", 1'b1, 6'd1, 6'd1, 32'hFFFFFFFE);
    set_op(4'd7, 1'b1, 1'b0, 32'd4, 32'h80000000, 32'd0, 6'd2, 6'd2);
    tick; chk1("sra", 1'b1, 6'd2, 6'd2, 32'hF8000000);
    set_op(4'd9, 1'b0, 1'b0, 32'd0, 32'd1, 32'hFFFFFFFF, 6'd3, 6'd4);
    tick; chk1("sltu", 1'b1, 6'd3, 6'd4, 32'd1);
    set_op(4'd8, 1'b0, 1'b0, 32'd0, 32'd1, 32'hFFFFFFFF, 6'd4, 6'd4);
    tick; chk1("slt", 1'b1, 6'd4, 6'd4, 32'd0);
    set_op(4'd10, 1'b1, 1'b0, 32'h12345000, 32'hDEAD, 32'd0, 6'd5, 6'd5);
    tick; chk1("lui", 1'b1, 6'd5, 6'd5, 32'h12345000);
    set_op(4'd13, 1'b0, 1'b0, 32'd0, 32'hFF, 32'hFF, 6'd6, 6'd6);
    tick; chk1("rsvd", 1'b1, 6'd6, 6'd6, 32'd0);
    set_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd7, 6'd0, 6'd10);
    tick; chk1("tag0", 1'b1, 6'd0, 6'd10, 32'd0);
    check("b2b.avail1", 32'(avail1), 32'd1);
    we1 = 1'b0;
    tick; chk1("idle", 1'b0, 6'd0, 6'd0, 32'd0);

    // Address generation ignores ALUControl/ALUSrc
    we1 = 1'b1;
    set_op(4'd1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h100, 32'd55, 6'd7, 6'd9);
    tick;
    check("ls.act", 32'(lwa1), 32'd1);
    check("ls.val", lval1, 32'h000000FC);
    check("ls.rob", 32'(lrob1), 32'd9);
    check("ls.wa", 32'(wa1), 32'd0);
    check("ls.wval", wval1, 32'd0);
    check("ls.wtag", 32'(wtag1), 32'd0);

    set_op(4'd4, 1'b0, 1'b0, 32'd0, 32'h0000F0F0, 32'h00000FF0, 6'd20, 6'd21);
    tick; chk1("b2b.xor", 1'b1, 6'd20, 6'd21, 32'h0000FF00);
    check("b2b.av0", 32'(avail1), 32'd1);
    set_op(4'd5, 1'b1, 1'b0, 32'd31, 32'd1, 32'd0, 6'd22, 6'd23);
    tick; chk1("b2b.sll", 1'b1, 6'd22, 6'd23, 32'h80000000);
    check("b2b.av1", 32'(avail1), 32'd1);
    set_op(4'd6, 1'b1, 1'b0, 32'd31, 32'h80000000, 32'd0, 6'd24, 6'd25);
    tick; chk1("b2b.srl", 1'b1, 6'd24, 6'd25, 32'd1);
    check("b2b.av2", 32'(avail1), 32'd1);
    we1 = 1'b0;
    tick; check("b2b.end", 32'(wa1), 32'd0);

    // LATENCY=3: two follow-up issues while busy must be dropped
    we3 = 1'b1;
    set_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd10, 32'd20, 6'd5, 6'd7);
    tick;
    check("l3.av_a", 32'(avail3), 32'd0);
    check("l3.wa_a", 32'(wa3), 32'd0);
    set_op(4'd0, 1'b0, 1'b0, 32'd0, 32'd100, 32'd100, 6'd6, 6'd8);
    tick;
    check("l3.av_b", 32'(avail3), 32'd0);
    check("l3.wa_b", 32'(wa3), 32'd0);
    tick;
    check("l3.wa", 32'(wa3), 32'd1);
    check("l3.val", wval3, 32'd30);
    check("l3.tag", 32'(wtag3), 32'd5);
    check("l3.rob", 32'(wrob3), 32'd7);
    check("l3.av_c", 32'(avail3), 32'd1);
    we3 = 1'b0;
    tick;
    check("l3.wa_d", 32'(wa3), 32'd0);
    check("l3.val_d", wval3, 32'd0);
    check("l3.av_d", 32'(avail3), 32'd1);

    // Reset one cycle after accept kills the in-flight op
    we3 = 1'b1;
    set_op(4'd4, 1'b0, 1'b0, 32'd0, 32'h0F, 32'h03, 6'd9, 6'd11);
    tick;
    we3 = 1'b0;
    tick;
    rst3 = 1'b1;
    #1;
    check("kill.av", 32'(avail3), 32'd1);
    check("kill.wa", 32'(wa3), 32'd0);
    tick;
    check("kill.wa2", 32'(wa3), 32'd0);
    check("kill.val2", wval3, 32'd0);
    check("kill.lwa2", 32'(lwa3), 32'd0);
    rst3 = 1'b0;

    // First edge after reset release accepts
    we3 = 1'b1;
    set_op(4'd0, 1'b0, 1'b1, 32'd8, 32'h200, 32'd0, 6'd0, 6'd12);
    tick;
    we3 = 1'b0;
    check("post.av", 32'(avail3), 32'd0);
    check("post.wa0", 32'(wa3), 32'd0);
    tick;
    check("post.lwa1", 32'(lwa3), 32'd0);
    tick;
    check("post.lwa", 32'(lwa3), 32'd1);
    check("post.lval", lval3, 32'h208);
    check("post.lrob", 32'(lrob3), 32'd12);
    check("post.wa", 32'(wa3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
